exec_ctrl: RTL and testbench
============================

Name: exec_ctrl

Overview:
- Execute-stage controller for the scalar core.
- Owns the ID/EX and EX/MEM pipeline registers.
- Drives the combinational executer from the ID/EX register and applies valid/ready handshakes on both sides.
- Qualifies the executer's branch_taken into a redirect/flush, substitutes link values for jumps, and halts the stage on ECALL/EBREAK until released.

Parameters:
- XLEN, 32, datapath width of pc/operands/result.
- RESUME_PC_INC, 4, pc increment used for link value and halt-resume pc.

Ports:
- clk  in  1  core clock, rising edge.
- rstn_i  in  1  asynchronous active-low reset.
- id_valid_i  in  1  decode bundle valid.
- id_ready_o  out  1  stage can accept bundle.
- id_instr_i  in  32  instruction word.
- id_pc_i  in  XLEN  instruction pc.
- id_rs1_i  in  XLEN  operand 1.
- id_rs2_i  in  XLEN  operand 2.
- id_imm_i  in  XLEN  immediate.
- id_rd_i  in  5  destination register.
- ex_instr_o, ex_pc_o, ex_rs1_o, ex_rs2_o, ex_imm_o  out  32/XLEN  registered bundle to executer.
- ex_result_i  in  XLEN  executer result.
- ex_branch_taken_i  in  1  executer branch flag.
- mem_valid_o  out  1  EX/MEM bundle valid.
- mem_ready_i  in  1  memory stage accepts.
- mem_instr_o  out  32  instruction.
- mem_pc_o  out  XLEN  pc.
- mem_result_o  out  XLEN  ALU result or link value.
- mem_store_data_o  out  XLEN  rs2 for stores.
- mem_rd_o  out  5  destination register.
- flush_o  out  1  redirect fetch/decode this cycle.
- branch_target_o  out  XLEN  redirect address.
- halted_o  out  1  stage in HALT.
- resume_i  in  1  leave HALT.

Behaviour:
- Reset (async on rstn_i low): ex_v=0, mem_valid_o=0, all registered data outputs 0, state=RUN, flush_o=0, halted_o=0.
- ex_v marks ID/EX occupancy. Define advance = ex_v & state==RUN & (!mem_valid_o | mem_ready_i).
- id_ready_o = state==RUN & (!ex_v | advance).
- ID/EX load: on id_valid_i & id_ready_o & !flush_o the bundle is captured and ex_v=1. Otherwise, if advance, ex_v=0.
- Flush wins over a simultaneous accept: the accepted wrong-path bundle is dropped and ex_v=0.
- Redirect condition: advance & (opcode JAL | JALR | (BRANCH & ex_branch_taken_i)). The AUIPC branch_taken is ignored (opcode mask).
- flush_o is combinational and asserts only in the advance cycle.
- branch_target_o = ex_result_i, with bit0 cleared for JALR. It is 0 when flush_o=0.
- EX/MEM register on advance: mem_valid_o=1 and fields captured.
  - mem_result_o = ex_pc+RESUME_PC_INC for JAL/JALR, else ex_result_i.
  - Untaken BRANCH still advances (no writeback, rd forwarded unchanged).
- When mem_valid_o & mem_ready_i & !advance: mem_valid_o=0.
- Stage latency is 1 cycle from accept to mem_valid_o with no backpressure. Full throughput is 1/cycle.
- mem_valid_o holds with all fields stable while mem_ready_i=0.
- FSM:
  - RUN -> HALT when an ECALL/EBREAK (opcode SYSTEM, funct3=0) advances. It is written to EX/MEM normally.
  - HALT: id_ready_o=0, halted_o=1, ex_v=0. The EX/MEM output drains normally.
  - HALT -> RUN on resume_i (edge-free level; one cycle sufficient).
  - resume_i in RUN is ignored.
- Reset mid-operation: all in-flight bundles are discarded immediately; no flush_o is generated.
- Unknown opcodes advance as NOP-equivalent (result passed through, no flush).

Optional Feature:
- Macro EXEC_CTRL_PERF_EN.
- When defined, adds output ports perf_retired_o[31:0] and perf_redirect_o[31:0].
  - perf_retired_o increments on each advance.
  - perf_redirect_o increments on each flush_o.
  - Both wrap 0xFFFFFFFF -> 0 and reset to 0.
- When undefined, no such ports or registers exist and behaviour is otherwise identical.

Decomposition:
- Package exec_pkg:
  - opcode constants (JAL, JALR, BRANCH, SYSTEM, STORE);
  - typedef ex_bundle_t (instr, pc, rs1, rs2, imm, rd);
  - typedef mem_bundle_t (instr, pc, result, store_data, rd);
  - enum exec_state_e {RUN, HALT}.
- One sub-module, exec_redirect, that is combinational: opcode/branch_taken/result in, flush and target out.
- Pipeline registers and FSM remain in exec_ctrl.

Test Plan:
- ADDI x1 accepted with mem_ready_i=1, ex_result_i=0x5 -> next cycle mem_valid_o=1, mem_result_o=0x5, mem_rd_o=1, flush_o never high.
- JAL at pc 0x100, ex_result_i=0x180 -> flush_o=1 for exactly one cycle, branch_target_o=0x180, mem_result_o=0x104. A bundle offered in the same cycle is dropped.
- JALR with ex_result_i=0x203 -> branch_target_o=0x202. AUIPC with ex_branch_taken_i=1 -> flush_o=0.
- mem_ready_i=0 for 3 cycles with a 3-deep id stream -> mem fields stable, id_ready_o=0 once ex_v=1. After release, all 3 retire in order with no loss or duplicate.
- ECALL advances -> halted_o=1 next cycle, id_ready_o=0 while id_valid_i=1. resume_i pulse -> id_ready_o=1 the following cycle.
- rstn_i low mid-stream with mem_valid_o=1 -> mem_valid_o=0 immediately (async). With EXEC_CTRL_PERF_EN, counters read 0; after 10 advances with 2 jumps they read 10/2.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared types and opcode constants for the execute-stage controller.
// The bundle structs are sized by EXEC_XLEN; exec_ctrl's XLEN parameter must match it.
package exec_pkg;

  localparam int EXEC_XLEN = 32;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  typedef struct packed {
    logic [31:0]          instr;
    logic [EXEC_XLEN-1:0] pc;
    logic [EXEC_XLEN-1:0] rs1;
    logic [EXEC_XLEN-1:0] rs2;
    logic [EXEC_XLEN-1:0] imm;
    logic [4:0]           rd;
  } ex_bundle_t;

  typedef struct packed {
    logic [31:0]          instr;
    logic [EXEC_XLEN-1:0] pc;
    logic [EXEC_XLEN-1:0] result;
    logic [EXEC_XLEN-1:0] store_data;
    logic [4:0]           rd;
  } mem_bundle_t;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } exec_state_e;

  function automatic logic is_jump(input logic [6:0] opc);
    return (opc == OPC_JAL) || (opc == OPC_JALR);
  endfunction

endpackage

// File: rtl/exec_redirect.sv
// Combinational redirect qualifier: decides whether the advancing instruction
// redirects fetch and computes the target. Only JAL/JALR/BRANCH can redirect,
// so a stray branch_taken on any other opcode (e.g. AUIPC) is masked off.
module exec_redirect
  import exec_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_advance,
  input  logic [6:0]      i_opcode,
  input  logic            i_branch_taken,
  input  logic [XLEN-1:0] i_result,
  output logic            o_flush,
  output logic [XLEN-1:0] o_target
);

  logic w_jalr;

  // flush qualification and target; target is forced to zero when not redirecting
  always_comb begin
    w_jalr   = (i_opcode == OPC_JALR);
    o_flush  = i_advance & (is_jump(i_opcode) |
                            ((i_opcode == OPC_BRANCH) & i_branch_taken));
    o_target = '0;
    if (o_flush) begin
      o_target = w_jalr ? {i_result[XLEN-1:1], 1'b0} : i_result;
    end
  end

endmodule

// File: rtl/exec_ctrl.sv
// Execute-stage controller: owns ID/EX and EX/MEM registers, handshakes,
// redirect/flush generation, link substitution and ECALL/EBREAK halt.
// Optional macro EXEC_CTRL_PERF_EN adds retired/redirect performance counters.
//
// state | meaning
// RUN   | normal flow, ID/EX advances into EX/MEM when downstream allows
// HALT  | ECALL/EBREAK retired, intake blocked until resume_i
module exec_ctrl
  import exec_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int RESUME_PC_INC = 4
) (
  input  logic            clk,
  input  logic            rstn_i,
  input  logic            id_valid_i,
  output logic            id_ready_o,
  input  logic [31:0]     id_instr_i,
  input  logic [XLEN-1:0] id_pc_i,
  input  logic [XLEN-1:0] id_rs1_i,
  input  logic [XLEN-1:0] id_rs2_i,
  input  logic [XLEN-1:0] id_imm_i,
  input  logic [4:0]      id_rd_i,
  output logic [31:0]     ex_instr_o,
  output logic [XLEN-1:0] ex_pc_o,
  output logic [XLEN-1:0] ex_rs1_o,
  output logic [XLEN-1:0] ex_rs2_o,
  output logic [XLEN-1:0] ex_imm_o,
  input  logic [XLEN-1:0] ex_result_i,
  input  logic            ex_branch_taken_i,
  output logic            mem_valid_o,
  input  logic            mem_ready_i,
  output logic [31:0]     mem_instr_o,
  output logic [XLEN-1:0] mem_pc_o,
  output logic [XLEN-1:0] mem_result_o,
  output logic [XLEN-1:0] mem_store_data_o,
  output logic [4:0]      mem_rd_o,
  output logic            flush_o,
  output logic [XLEN-1:0] branch_target_o,
  output logic            halted_o,
  input  logic            resume_i
`ifdef EXEC_CTRL_PERF_EN
  ,
  output logic [31:0]     perf_retired_o,
  output logic [31:0]     perf_redirect_o
`endif
);

  exec_state_e r_state;
  exec_state_e w_state_nxt;
  ex_bundle_t  r_ex;
  logic        r_ex_v;
  mem_bundle_t r_mem;
  mem_bundle_t w_mem_nxt;
  logic        r_mem_v;
  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic        w_advance;
  logic        w_flush;
  logic        w_halt_req;
  logic        w_accept;

  assign w_opcode  = r_ex.instr[6:0];
  assign w_funct3  = r_ex.instr[14:12];
  assign w_advance = r_ex_v & (r_state == RUN) & (~r_mem_v | mem_ready_i);

  exec_redirect #(.XLEN(XLEN)) u_redirect (
    .i_advance      (w_advance),
    .i_opcode       (w_opcode),
    .i_branch_taken (ex_branch_taken_i),
    .i_result       (ex_result_i),
    .o_flush        (w_flush),
    .o_target       (branch_target_o)
  );

  assign flush_o = w_flush;

  // FSM state register
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) r_state <= RUN;
    else         r_state <= w_state_nxt;
  end

  // next state and intake handshake; intake is closed in the cycle a halting
  // instruction advances so nothing is left stranded in ID/EX during HALT
  always_comb begin
    w_state_nxt = r_state;
    w_halt_req  = 1'b0;
    id_ready_o  = 1'b0;
    halted_o    = 1'b0;
    case (r_state)
      RUN: begin
        w_halt_req = w_advance & (w_opcode == OPC_SYSTEM) & (w_funct3 == 3'b000);
        id_ready_o = (~r_ex_v | w_advance) & ~w_halt_req;
        if (w_halt_req) w_state_nxt = HALT;
      end
      HALT: begin
        halted_o = 1'b1;
        if (resume_i) w_state_nxt = RUN;
      end
      default: w_state_nxt = RUN;
    endcase
  end

  // a bundle accepted while the stage redirects is wrong-path and is dropped
  assign w_accept = id_valid_i & id_ready_o & ~w_flush;

  // ID/EX register
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      r_ex   <= '0;
      r_ex_v <= 1'b0;
    end else if (w_accept) begin
      r_ex   <= '{instr: id_instr_i, pc: id_pc_i, rs1: id_rs1_i,
                  rs2: id_rs2_i, imm: id_imm_i, rd: id_rd_i};
      r_ex_v <= 1'b1;
    end else if (w_advance) begin
      r_ex_v <= 1'b0;
    end
  end

  // EX/MEM payload: jumps write the link value; store data is zeroed for
  // non-stores so the memory stage never sees stale operands on the bus
  always_comb begin
    w_mem_nxt            = '0;
    w_mem_nxt.instr      = r_ex.instr;
    w_mem_nxt.pc         = r_ex.pc;
    w_mem_nxt.result     = is_jump(w_opcode) ? (r_ex.pc + EXEC_XLEN'(RESUME_PC_INC))
                                             : ex_result_i;
    w_mem_nxt.store_data = (w_opcode == OPC_STORE) ? r_ex.rs2 : '0;
    w_mem_nxt.rd         = r_ex.rd;
  end

  // EX/MEM register; fields only change on advance so they hold under backpressure
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      r_mem   <= '0;
      r_mem_v <= 1'b0;
    end else if (w_advance) begin
      r_mem   <= w_mem_nxt;
      r_mem_v <= 1'b1;
    end else if (r_mem_v & mem_ready_i) begin
      r_mem_v <= 1'b0;
    end
  end

  assign ex_instr_o       = r_ex.instr;
  assign ex_pc_o          = r_ex.pc;
  assign ex_rs1_o         = r_ex.rs1;
  assign ex_rs2_o         = r_ex.rs2;
  assign ex_imm_o         = r_ex.imm;
  assign mem_valid_o      = r_mem_v;
  assign mem_instr_o      = r_mem.instr;
  assign mem_pc_o         = r_mem.pc;
  assign mem_result_o     = r_mem.result;
  assign mem_store_data_o = r_mem.store_data;
  assign mem_rd_o         = r_mem.rd;

`ifdef EXEC_CTRL_PERF_EN
  logic [31:0] r_perf_retired;
  logic [31:0] r_perf_redirect;

  // free-running wrap-around event counters
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      r_perf_retired  <= '0;
      r_perf_redirect <= '0;
    end else begin
      if (w_advance) r_perf_retired  <= r_perf_retired + 32'd1;
      if (w_flush)   r_perf_redirect <= r_perf_redirect + 32'd1;
    end
  end

  assign perf_retired_o  = r_perf_retired;
  assign perf_redirect_o = r_perf_redirect;
`endif

endmodule

// File: tb/tb_exec_ctrl.sv
// Bench for exec_ctrl: directed scenarios plus randomized traffic, all checked
// against a transaction-level queue model of the two pipeline slots.
module tb_exec_ctrl;

  localparam logic [6:0] T_JAL    = 7'b1101111;
  localparam logic [6:0] T_JALR   = 7'b1100111;
  localparam logic [6:0] T_BRANCH = 7'b1100011;
  localparam logic [6:0] T_SYSTEM = 7'b1110011;
  localparam logic [6:0] T_STORE  = 7'b0100011;
  localparam logic [6:0] T_AUIPC  = 7'b0010111;
  localparam logic [6:0] T_OPIMM  = 7'b0010011;
  localparam logic [6:0] T_CUSTOM = 7'b0001011;

  logic        clk = 1'b0;
  logic        rstn_i = 1'b0;
  logic        id_valid_i = 1'b0;
  logic        id_ready_o;
  logic [31:0] id_instr_i = '0, id_pc_i = '0, id_rs1_i = '0, id_rs2_i = '0, id_imm_i = '0;
  logic [4:0]  id_rd_i = '0;
  logic [31:0] ex_instr_o, ex_pc_o, ex_rs1_o, ex_rs2_o, ex_imm_o;
  logic [31:0] ex_result_i = '0;
  logic        ex_branch_taken_i = 1'b0;
  logic        mem_valid_o;
  logic        mem_ready_i = 1'b1;
  logic [31:0] mem_instr_o, mem_pc_o, mem_result_o, mem_store_data_o;
  logic [4:0]  mem_rd_o;
  logic        flush_o;
  logic [31:0] branch_target_o;
  logic        halted_o;
  logic        resume_i = 1'b0;
`ifdef EXEC_CTRL_PERF_EN
  logic [31:0] perf_retired_o, perf_redirect_o;
`endif

  exec_ctrl dut (
    .clk(clk), .rstn_i(rstn_i),
    .id_valid_i(id_valid_i), .id_ready_o(id_ready_o), .id_instr_i(id_instr_i),
    .id_pc_i(id_pc_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_imm_i(id_imm_i),
    .id_rd_i(id_rd_i),
    .ex_instr_o(ex_instr_o), .ex_pc_o(ex_pc_o), .ex_rs1_o(ex_rs1_o), .ex_rs2_o(ex_rs2_o),
    .ex_imm_o(ex_imm_o), .ex_result_i(ex_result_i), .ex_branch_taken_i(ex_branch_taken_i),
    .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i), .mem_instr_o(mem_instr_o),
    .mem_pc_o(mem_pc_o), .mem_result_o(mem_result_o), .mem_store_data_o(mem_store_data_o),
    .mem_rd_o(mem_rd_o), .flush_o(flush_o), .branch_target_o(branch_target_o),
    .halted_o(halted_o), .resume_i(resume_i)
`ifdef EXEC_CTRL_PERF_EN
    , .perf_retired_o(perf_retired_o), .perf_redirect_o(perf_redirect_o)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // reference model: one optional bundle in EX, one optional result in MEM
  typedef struct packed {
    logic [31:0] instr, pc, rs1, rs2, imm;
    logic [4:0]  rd;
  } bun_t;
  typedef struct packed {
    logic [31:0] instr, pc, result, sdata;
    logic [4:0]  rd;
  } mres_t;

  bun_t  ex_q[$];
  mres_t mem_q[$];
  bit    m_halted = 0;
  int    m_adv_cnt = 0;
  int    m_redir_cnt = 0;
  bit    e_go, e_redirect, e_sys, e_ready;
  logic [6:0]  e_op;
  logic [31:0] e_target;

  task automatic model_eval();
    e_go = (ex_q.size() != 0) && !m_halted && (mem_q.size() == 0 || mem_ready_i);
    e_op = (ex_q.size() != 0) ? ex_q[0].instr[6:0] : 7'd0;
    e_redirect = e_go && (e_op == T_JAL || e_op == T_JALR ||
                          (e_op == T_BRANCH && ex_branch_taken_i));
    e_sys = e_go && (e_op == T_SYSTEM) && (ex_q[0].instr[14:12] == 3'd0);
    e_ready = !m_halted && (ex_q.size() == 0 || e_go) && !e_sys;
    e_target = 32'd0;
    if (e_redirect) e_target = (e_op == T_JALR) ? (ex_result_i & ~32'd1) : ex_result_i;
  endtask

  task automatic model_check();
    chk("id_ready", {31'd0, id_ready_o}, {31'd0, e_ready});
    chk("flush", {31'd0, flush_o}, {31'd0, e_redirect});
    chk("target", branch_target_o, e_target);
    chk("halted", {31'd0, halted_o}, {31'd0, m_halted});
    chk("mem_valid", {31'd0, mem_valid_o}, {31'd0, mem_q.size() != 0});
    if (mem_q.size() != 0) begin
      chk("mem_instr", mem_instr_o, mem_q[0].instr);
      chk("mem_pc", mem_pc_o, mem_q[0].pc);
      chk("mem_result", mem_result_o, mem_q[0].result);
      chk("mem_sdata", mem_store_data_o, mem_q[0].sdata);
      chk("mem_rd", {27'd0, mem_rd_o}, {27'd0, mem_q[0].rd});
    end
    if (ex_q.size() != 0) begin
      chk("ex_instr", ex_instr_o, ex_q[0].instr);
      chk("ex_pc", ex_pc_o, ex_q[0].pc);
      chk("ex_rs1", ex_rs1_o, ex_q[0].rs1);
      chk("ex_rs2", ex_rs2_o, ex_q[0].rs2);
      chk("ex_imm", ex_imm_o, ex_q[0].imm);
    end
`ifdef EXEC_CTRL_PERF_EN
    chk("perf_retired", perf_retired_o, 32'(m_adv_cnt));
    chk("perf_redirect", perf_redirect_o, 32'(m_redir_cnt));
`endif
  endtask

  task automatic cyc(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                     input logic [4:0] rd, input logic [31:0] res, input logic tk,
                     input logic mrdy, input logic rsm);
    id_valid_i = v; id_instr_i = ins; id_pc_i = pc; id_rd_i = rd;
    id_rs1_i = $urandom; id_rs2_i = $urandom; id_imm_i = $urandom;
    ex_result_i = res; ex_branch_taken_i = tk; mem_ready_i = mrdy; resume_i = rsm;
    #1;
    model_eval();
    model_check();
  endtask

  task automatic tick();
    mres_t m;
    bun_t  b;
    if (mem_q.size() != 0 && mem_ready_i) void'(mem_q.pop_front());
    if (e_go) begin
      b = ex_q.pop_front();
      m.instr  = b.instr;
      m.pc     = b.pc;
      m.result = (e_op == T_JAL || e_op == T_JALR) ? b.pc + 32'd4 : ex_result_i;
      m.sdata  = (e_op == T_STORE) ? b.rs2 : 32'd0;
      m.rd     = b.rd;
      mem_q.push_back(m);
      m_adv_cnt++;
      if (e_redirect) m_redir_cnt++;
    end
    if (id_valid_i && e_ready && !e_redirect) begin
      b = '{instr: id_instr_i, pc: id_pc_i, rs1: id_rs1_i, rs2: id_rs2_i,
            imm: id_imm_i, rd: id_rd_i};
      ex_q.push_back(b);
    end
    if (e_sys) m_halted = 1;
    else if (m_halted && resume_i) m_halted = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, 32'd0, 32'd0, 5'd0, $urandom, 1'b0, 1'b1, 1'b1);
      tick();
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    int k;
    r = $urandom;
    k = $urandom_range(0, 10);
    case (k)
      0: r[6:0] = T_JAL;
      1: begin r[6:0] = T_JALR; r[14:12] = 3'd0; end
      2, 3: r[6:0] = T_BRANCH;
      4: r = 32'h0000_0073;
      5: r = 32'h0010_0073;
      6: begin r[6:0] = T_SYSTEM; if (r[14:12] == 3'd0) r[14:12] = 3'd2; end
      7: r[6:0] = T_AUIPC;
      8: r[6:0] = T_STORE;
      9: r[6:0] = T_CUSTOM;
      default: r[6:0] = T_OPIMM;
    endcase
    return r;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]  seen[$];
    logic [31:0] r;
    logic        mr;
    int          sent;

    // reset state
    #3;
    chk("rst_mem_valid", {31'd0, mem_valid_o}, 32'd0);
    chk("rst_flush", {31'd0, flush_o}, 32'd0);
    chk("rst_halted", {31'd0, halted_o}, 32'd0);
    chk("rst_id_ready", {31'd0, id_ready_o}, 32'd1);
    chk("rst_mem_result", mem_result_o, 32'd0);
    chk("rst_ex_pc", ex_pc_o, 32'd0);
    @(negedge clk);
    rstn_i = 1'b1;
    @(posedge clk);
    #1;

    // ADDI x1 = 5
    cyc(1'b1, 32'h0050_0093, 32'h0, 5'd1, 32'h0, 1'b0, 1'b1, 1'b0); tick();
    cyc(1'b0, 32'h0, 32'h0, 5'd0, 32'h5, 1'b0, 1'b1, 1'b0);
    chk("addi_flush", {31'd0, flush_o}, 32'd0);
    tick();
    cyc(1'b0, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("addi_mem_valid", {31'd0, mem_valid_o}, 32'd1);
    chk("addi_result", mem_result_o, 32'h5);
    chk("addi_rd", {27'd0, mem_rd_o}, 32'd1);
    tick();

    // JAL at 0x100 with a wrong-path bundle offered during the flush
    cyc(1'b1, 32'h0800_00EF, 32'h100, 5'd1, 32'h0, 1'b0, 1'b1, 1'b0); tick();
    cyc(1'b1, 32'h0070_0113, 32'h104, 5'd2, 32'h180, 1'b0, 1'b1, 1'b0);
    chk("jal_flush", {31'd0, flush_o}, 32'd1);
    chk("jal_target", branch_target_o, 32'h180);
    tick();
    cyc(1'b0, 32'h0, 32'h0, 5'd0, 32'h180, 1'b0, 1'b1, 1'b0);
    chk("jal_flush_once", {31'd0, flush_o}, 32'd0);
    chk("jal_link", mem_result_o, 32'h104);
    tick();
    cyc(1'b0, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("jal_wrongpath_dropped", {31'd0, mem_valid_o}, 32'd0);
    tick();

    // JALR target bit0 cleared; AUIPC ignores branch_taken
    cyc(1'b1, 32'h0000_80E7, 32'h200, 5'd1, 32'h0, 1'b0, 1'b1, 1'b0); tick();
    cyc(1'b0, 32'h0, 32'h0, 5'd0, 32'h203, 1'b0, 1'b1, 1'b0);
    chk("jalr_target", branch_target_o, 32'h202);
    tick();
    cyc(1'b1, 32'h0000_0097, 32'h300, 5'd1, 32'h0, 1'b0, 1'b1, 1'b0); tick();
    cyc(1'b0, 32'h0, 32'h0, 5'd0, 32'h1234, 1'b1, 1'b1, 1'b0);
    chk("auipc_no_flush", {31'd0, flush_o}, 32'd0);
    tick();
    cyc(1'b0, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("auipc_result", mem_result_o, 32'h1234);
    tick();

    // backpressure on a 3-deep stream
    sent = 0;
    for (int c = 0; c < 10; c++) begin
      r  = (ex_q.size() != 0) ? 32'h11 * ex_q[0].rd : 32'h0;
      mr = !(c >= 2 && c < 5);
      cyc(sent < 3, 32'h0000_0013, 32'h400 + 32'(4 * sent), 5'(sent + 1), r, 1'b0, mr, 1'b0);
      if (c == 3) chk("bp_id_ready_low", {31'd0, id_ready_o}, 32'd0);
      if (c == 4) chk("bp_hold_rd", {27'd0, mem_rd_o}, 32'd1);
      if (mem_valid_o && mem_ready_i) seen.push_back(mem_rd_o);
      if (sent < 3 && e_ready) sent++;
      tick();
    end
    chk("bp_count", 32'(seen.size()), 32'd3);
    for (int i = 0; i < seen.size(); i++) chk("bp_order", {27'd0, seen[i]}, 32'(i + 1));

    // ECALL halts until resume
    cyc(1'b1, 32'h0000_0073, 32'h500, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0); tick();
    cyc(1'b1, 32'h0000_0193, 32'h504, 5'd3, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("ecall_adv_no_accept", {31'd0, id_ready_o}, 32'd0);
    tick();
    cyc(1'b1, 32'h0000_0193, 32'h504, 5'd3, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("halt_halted", {31'd0, halted_o}, 32'd1);
    chk("halt_id_ready", {31'd0, id_ready_o}, 32'd0);
    tick();
    cyc(1'b1, 32'h0000_0193, 32'h504, 5'd3, 32'h0, 1'b0, 1'b1, 1'b1);
    chk("halt_during_resume", {31'd0, halted_o}, 32'd1);
    tick();
    cyc(1'b1, 32'h0000_0193, 32'h504, 5'd3, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("resume_id_ready", {31'd0, id_ready_o}, 32'd1);
    chk("resume_halted", {31'd0, halted_o}, 32'd0);
    tick();
    idle(3);

    // async reset with a valid EX/MEM bundle
    cyc(1'b1, 32'h0000_0213, 32'h600, 5'd4, 32'h0, 1'b0, 1'b0, 1'b0); tick();
    cyc(1'b1, 32'h0000_0293, 32'h604, 5'd5, 32'h44, 1'b0, 1'b0, 1'b0); tick();
    cyc(1'b0, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_mem_valid", {31'd0, mem_valid_o}, 32'd1);
    rstn_i = 1'b0;
    #1;
    chk("async_rst_mem_valid", {31'd0, mem_valid_o}, 32'd0);
    chk("async_rst_flush", {31'd0, flush_o}, 32'd0);
    chk("async_rst_mem_result", mem_result_o, 32'd0);
    ex_q.delete(); mem_q.delete(); m_halted = 0; m_adv_cnt = 0; m_redir_cnt = 0;
`ifdef EXEC_CTRL_PERF_EN
    chk("perf_rst_retired", perf_retired_o, 32'd0);
    chk("perf_rst_redirect", perf_redirect_o, 32'd0);
`endif
    @(negedge clk);
    rstn_i = 1'b1;
    @(posedge clk);
    #1;

    // 10 advances, 2 of them jumps
    for (int i = 0; i < 10; i++) begin
      r = (i == 3 || i == 7) ? 32'h0100_006F : 32'h0000_0013;
      cyc(1'b1, r, 32'h700 + 32'(8 * i), 5'd6, 32'h0, 1'b0, 1'b1, 1'b0); tick();
      cyc(1'b0, 32'h0, 32'h0, 5'd0, $urandom, 1'b0, 1'b1, 1'b0); tick();
    end
    cyc(1'b0, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0);
`ifdef EXEC_CTRL_PERF_EN
    chk("perf_retired_10", perf_retired_o, 32'd10);
    chk("perf_redirect_2", perf_redirect_o, 32'd2);
`endif
    tick();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 3) != 0, rand_instr(), $urandom & ~32'd3, 5'($urandom),
          $urandom, 1'($urandom), $urandom_range(0, 9) < 7, $urandom_range(0, 7) == 0);
      tick();
    end
    idle(6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
